// File: rtl/router_ingress_arb.sv
// router_ingress_arb
//   Packet-level round-robin arbiter in front of the 1x3 router's single input.
//   One source is granted per packet. Its header, payload and parity bytes are
//   passed to the router with no added latency. Router busy is forwarded as
//   back-pressure to the granted source. The header length and address fields
//   are checked.
//
// Ports
//   clock, reset   clock; synchronous active-high reset
//   src_pkt_valid  per-source pkt_valid (high for header/payload, low for parity)
//   src_data       per-source byte, source i at [8i+7:8i]
//   src_en         arbitration enable mask
//   src_ready      byte on src_data[i] accepted this cycle (combinational)
//   busy           router busy; no byte is accepted while high
//   pkt_valid      router pkt_valid (combinational)
//   data_in        router data_in (combinational)
//   grant_id       currently or last granted source
//   arb_active     high while a packet is being passed
//   pkt_done       one-cycle pulse after the parity byte is accepted
//   len_err        one-cycle pulse with pkt_done when payload count != header length
//   addr_err       one-cycle pulse after a header with address 2'b11 is accepted
module router_ingress_arb #(
    parameter int unsigned N_SRC = 3,
    parameter int unsigned GW    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_SRC-1:0]     src_pkt_valid,
    input  logic [8*N_SRC-1:0]   src_data,
    input  logic [N_SRC-1:0]     src_en,
    output logic [N_SRC-1:0]     src_ready,
    input  logic                 busy,
    output logic                 pkt_valid,
    output logic [7:0]           data_in,
    output logic [GW-1:0]        grant_id,
    output logic                 arb_active,
    output logic                 pkt_done,
    output logic                 len_err,
    output logic                 addr_err
);

    localparam int unsigned BW = 8;
    localparam int unsigned CW = 6;

    typedef enum logic {S_IDLE, S_PASS} state_e;

    state_e          state;
    state_e          state_nxt;
    logic [N_SRC-1:0] req;
    logic [GW-1:0]   winner;
    logic            win_vld;
    logic [BW-1:0]   src_byte [N_SRC];
    logic            g_valid;
    logic [BW-1:0]   g_byte;
    logic            accept;
    logic            hdr_seen;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   hdr_len;
    logic [GW-1:0]   rr_ptr;

    // Unpack the flat source byte bus
    for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
        assign src_byte[i] = src_data[BW*i +: BW];
    end

    assign req = src_pkt_valid & src_en;

    // Round-robin winner: search first above rr_ptr, then wrap from 0
    always_comb begin
        win_vld = 1'b0;
        winner  = rr_ptr;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (!win_vld && req[i] && (GW'(i) > rr_ptr)) begin
                win_vld = 1'b1;
                winner  = GW'(i);
            end
        end
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (!win_vld && req[i] && (GW'(i) <= rr_ptr)) begin
                win_vld = 1'b1;
                winner  = GW'(i);
            end
        end
    end

    // Granted source's valid/byte
    always_comb begin
        g_valid = 1'b0;
        g_byte  = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (GW'(i) == grant_id) begin
                g_valid = src_pkt_valid[i];
                g_byte  = src_byte[i];
            end
        end
    end

    assign accept = (state == S_PASS) && !busy;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a byte accepted with pkt_valid low is the parity byte
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (win_vld && !busy)   state_nxt = S_PASS;
            S_PASS: if (accept && !g_valid) state_nxt = S_IDLE;
            default:                        state_nxt = S_IDLE;
        endcase
    end

    // Output logic: zero-latency data path from the granted source
    always_comb begin
        pkt_valid  = 1'b0;
        data_in    = '0;
        src_ready  = '0;
        arb_active = 1'b0;
        if (state == S_PASS) begin
            arb_active = 1'b1;
            pkt_valid  = g_valid;
            data_in    = g_byte;
            for (int unsigned i = 0; i < N_SRC; i++) begin
                if (GW'(i) == grant_id) src_ready[i] = !busy;
            end
        end
    end

    // Grant, round-robin pointer, header/payload tracking and status pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_id <= '0;
            rr_ptr   <= GW'(N_SRC - 1);
            cnt      <= '0;
            hdr_len  <= '0;
            hdr_seen <= 1'b0;
            pkt_done <= 1'b0;
            len_err  <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            len_err  <= 1'b0;
            addr_err <= 1'b0;
            if ((state == S_IDLE) && win_vld && !busy) begin
                grant_id <= winner;
                hdr_seen <= 1'b0;
            end
            if (accept) begin
                if (!g_valid) begin
                    // Parity in the header slot means no header at all: always a length error
                    pkt_done <= 1'b1;
                    len_err  <= !hdr_seen || (cnt != hdr_len);
                    rr_ptr   <= grant_id;
                end else if (!hdr_seen) begin
                    hdr_seen <= 1'b1;
                    hdr_len  <= g_byte[7:2];
                    cnt      <= '0;
                    addr_err <= (g_byte[1:0] == 2'b11);
                end else if (cnt != {CW{1'b1}}) begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule
